bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_updown_counter.sv | 109 ++++++++++
 tb/tb_bcd_updown_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD widths, limits, state type and load saturation helper
package bcd_pkg;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   // Non-BCD nibbles (A..F) are clamped to 9 so the counter never holds an illegal digit
   function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit: next value and carry/borrow for an up or down step
module bcd_digit
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] i_value,
   input  logic             i_up,
   input  logic             i_step_in,
   output logic [BCD_W-1:0] o_next,
   output logic             o_carry
);

   // Digit moves only when every lower digit wrapped; wrapping propagates carry/borrow upward
   always_comb begin
      o_next  = i_value;
      o_carry = 1'b0;
      if (i_step_in) begin
         if (i_up) begin
            if (i_value >= BCD_MAX) begin
               o_next  = '0;
               o_carry = 1'b1;
            end else begin
               o_next = i_value + BCD_W'(1);
            end
         end else begin
            if (i_value == '0) begin
               o_next  = BCD_MAX;
               o_carry = 1'b1;
            end else begin
               o_next = i_value - BCD_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - prescaled BCD up/down counter with wrap or stop-at-terminal
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1,
   parameter bit WRAP     = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic                  i_up,
   input  logic                  i_load,
   input  logic [BCD_W*DIGITS-1:0] i_load_value,
   input  logic                  i_clear,
   output logic [BCD_W*DIGITS-1:0] o_digits,
   output logic                  o_terminal,
   output logic                  o_done
);

   localparam int            DW     = BCD_W * DIGITS;
   localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

   logic [DW-1:0]   r_digits;
   logic [PW-1:0]   r_presc;
   state_t          r_state;
   logic            r_terminal;
   logic            r_up_q;

   logic [DW-1:0]   w_next;
   logic [DW-1:0]   w_load_sat;
   logic [DW-1:0]   w_term_val;
   logic [DIGITS:0] w_chain;
   logic            w_tick;
   logic            w_at_term;
   logic            w_next_is_term;

   // Ripple chain always computes the would-be next value; it is only committed on a tick
   assign w_chain[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .i_value   (r_digits[g*BCD_W +: BCD_W]),
         .i_up      (i_up),
         .i_step_in (w_chain[g]),
         .o_next    (w_next[g*BCD_W +: BCD_W]),
         .o_carry   (w_chain[g+1])
      );
      assign w_load_sat[g*BCD_W +: BCD_W] = bcd_sat(i_load_value[g*BCD_W +: BCD_W]);
   end

   assign w_term_val     = i_up ? {DIGITS{BCD_MAX}} : '0;
   assign w_at_term      = (r_digits == w_term_val);
   assign w_next_is_term = (w_next == w_term_val);
   assign w_tick         = i_enable && (r_state == RUN) && (r_presc == P_LAST);

   // Prescaler: free-runs 0..PRESCALE-1 while enabled in RUN, restarts on clear/load
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= '0;
      end else if (i_clear || i_load) begin
         r_presc <= '0;
      end else if (i_enable && (r_state == RUN)) begin
         r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
      end
   end

   // Count register, RUN/DONE state and terminal pulse; clear beats load beats a tick step
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_digits   <= '0;
         r_state    <= RUN;
         r_terminal <= 1'b0;
         r_up_q     <= 1'b0;
      end else begin
         r_up_q     <= i_up;
         r_terminal <= 1'b0;
         if (i_clear) begin
            r_digits <= '0;
            r_state  <= RUN;
         end else if (i_load) begin
            r_digits <= w_load_sat;
            r_state  <= RUN;
         end else if (w_tick) begin
            if (WRAP) begin
               r_digits   <= w_next;
               r_terminal <= w_chain[DIGITS];
            end else if (w_at_term) begin
               r_terminal <= 1'b1;
               r_state    <= DONE;
            end else begin
               r_digits <= w_next;
               if (w_next_is_term) begin
                  r_terminal <= 1'b1;
                  r_state    <= DONE;
               end
            end
         end else if ((r_state == DONE) && (i_up != r_up_q)) begin
            r_state <= RUN;
         end
      end
   end

   assign o_digits   = r_digits;
   assign o_terminal = r_terminal;
   assign o_done     = (r_state == DONE);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - three counter variants driven together and checked against an integer model
module tb_bcd_updown_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        up = 1'b0;
   logic        load = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] lv = 16'h0000;

   logic [15:0] dig [3];
   logic        term [3];
   logic        done [3];

   int total = 0;
   int bad = 0;

   // instance 0: wrap, prescale 1; instance 1: stop, prescale 1; instance 2: wrap, prescale 3
   int mp [3] = '{1, 1, 3};
   int mw [3] = '{1, 0, 1};

   int m_val   [3];
   int m_presc [3];
   bit m_done  [3];
   bit m_term  [3];
   bit m_upq;
   bit mt;
   int mtv;

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(4), .PRESCALE(1), .WRAP(1'b1)) u0 (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_up(up), .i_load(load),
      .i_load_value(lv), .i_clear(clear),
      .o_digits(dig[0]), .o_terminal(term[0]), .o_done(done[0]));

   bcd_updown_counter #(.DIGITS(4), .PRESCALE(1), .WRAP(1'b0)) u1 (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_up(up), .i_load(load),
      .i_load_value(lv), .i_clear(clear),
      .o_digits(dig[1]), .o_terminal(term[1]), .o_done(done[1]));

   bcd_updown_counter #(.DIGITS(4), .PRESCALE(3), .WRAP(1'b1)) u2 (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_up(up), .i_load(load),
      .i_load_value(lv), .i_clear(clear),
      .o_digits(dig[2]), .o_terminal(term[2]), .o_done(done[2]));

   function automatic int load_int(input logic [15:0] v);
      int r = 0;
      int m = 1;
      for (int i = 0; i < 4; i++) begin
         int d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         r += d * m;
         m *= 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      int x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Integer model: count value as a plain number, terminal as 9999/0
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            m_val[k] = 0; m_presc[k] = 0; m_done[k] = 0; m_term[k] = 0;
         end
         m_upq = 0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            mt  = en && !m_done[k] && (m_presc[k] == mp[k] - 1);
            mtv = up ? 9999 : 0;
            m_term[k] = 0;
            if (clear) begin
               m_val[k] = 0; m_presc[k] = 0; m_done[k] = 0;
            end else if (load) begin
               m_val[k] = load_int(lv); m_presc[k] = 0; m_done[k] = 0;
            end else begin
               if (en && !m_done[k]) m_presc[k] = (m_presc[k] + 1) % mp[k];
               if (mt) begin
                  if (m_val[k] == mtv) begin
                     m_term[k] = 1;
                     if (mw[k] != 0) m_val[k] = up ? 0 : 9999;
                     else m_done[k] = 1;
                  end else begin
                     m_val[k] = up ? m_val[k] + 1 : m_val[k] - 1;
                     if (mw[k] == 0 && m_val[k] == mtv) begin
                        m_term[k] = 1; m_done[k] = 1;
                     end
                  end
               end else if (m_done[k] && (up != m_upq)) begin
                  m_done[k] = 0;
               end
            end
         end
         m_upq = up;
      end
   end

   // Every-cycle comparison of all three instances against the model
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("u%0d_digits", k), 32'(dig[k]), 32'(to_bcd(m_val[k])));
         chk($sformatf("u%0d_terminal", k), 32'(term[k]), 32'(m_term[k]));
         chk($sformatf("u%0d_done", k), 32'(done[k]), 32'(m_done[k]));
      end
   end

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_digits", 32'(dig[0]), 32'h0);
      chk("rst_term", 32'(term[1]), 32'h0);
      chk("rst_done", 32'(done[1]), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // down through zero: wrap to 9999 vs stop at 0000
      up = 0; lv = 16'h0001; load = 1; step(1); load = 0;
      chk("load_0001", 32'(dig[0]), 32'h0001);
      en = 1; step(1);
      chk("dn_0000", 32'(dig[0]), 32'h0000);
      chk("dn_0000_noterm", 32'(term[0]), 32'h0);
      chk("stop_term", 32'(term[1]), 32'h1);
      chk("stop_done", 32'(done[1]), 32'h1);
      step(1);
      chk("wrap_9999", 32'(dig[0]), 32'h9999);
      chk("wrap_term", 32'(term[0]), 32'h1);
      chk("stop_hold", 32'(dig[1]), 32'h0000);
      chk("presc3_nostep", 32'(dig[2]), 32'h0001);
      en = 0;

      // up carry ripple and load saturation
      up = 1; lv = 16'h0199; load = 1; step(1); load = 0;
      en = 1; step(1); en = 0;
      chk("up_0200", 32'(dig[0]), 32'h0200);
      lv = 16'h09A9; load = 1; step(1); load = 0;
      chk("load_sat", 32'(dig[0]), 32'h0999);

      // stop mode landing on 0000, holding, then clear
      up = 0; lv = 16'h0002; load = 1; step(1); load = 0;
      en = 1; step(1);
      chk("stop_0001", 32'(dig[1]), 32'h0001);
      step(1);
      chk("stop_land", 32'(dig[1]), 32'h0000);
      chk("stop_land_term", 32'(term[1]), 32'h1);
      step(1);
      chk("stop_held_done", 32'(done[1]), 32'h1);
      chk("stop_held_term", 32'(term[1]), 32'h0);
      en = 0; clear = 1; step(1); clear = 0;
      chk("clear_undone", 32'(done[1]), 32'h0);

      // step attempted at terminal, then leave DONE by flipping direction
      en = 1; step(1); en = 0;
      chk("at_term_term", 32'(term[1]), 32'h1);
      chk("at_term_done", 32'(done[1]), 32'h1);
      up = 1; step(1);
      chk("upflip_run", 32'(done[1]), 32'h0);
      en = 1; step(1); en = 0;
      chk("upflip_0001", 32'(dig[1]), 32'h0001);

      // prescale 3: nine enabled cycles give three steps, disable freezes
      clear = 1; step(1); clear = 0;
      en = 1; step(9); en = 0;
      chk("presc_0003", 32'(dig[2]), 32'h0003);
      step(5);
      chk("presc_hold", 32'(dig[2]), 32'h0003);
      en = 1; step(2);
      chk("presc_partial", 32'(dig[2]), 32'h0003);
      step(1); en = 0;
      chk("presc_0004", 32'(dig[2]), 32'h0004);

      // load and clear beat a coincident tick
      en = 1; lv = 16'h1234; load = 1; step(1); load = 0;
      chk("load_wins", 32'(dig[0]), 32'h1234);
      chk("load_wins_term", 32'(term[0]), 32'h0);
      clear = 1; step(1); clear = 0;
      chk("clear_wins", 32'(dig[0]), 32'h0000);
      step(3);
      chk("count_0003", 32'(dig[0]), 32'h0003);

      // asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      chk("async_rst", 32'(dig[0]), 32'h0000);
      @(negedge clk);
      rst = 1'b0; en = 0;
      step(1);
      chk("post_rst_idle", 32'(dig[0]), 32'h0000);
      en = 1; step(1); en = 0;
      chk("post_rst_step", 32'(dig[0]), 32'h0001);

      // up from 9999: wrap to 0000 vs attempted step at terminal
      lv = 16'h9999; load = 1; step(1); load = 0;
      en = 1; step(1); en = 0;
      chk("upwrap_0000", 32'(dig[0]), 32'h0000);
      chk("upwrap_term", 32'(term[0]), 32'h1);
      chk("upstop_hold", 32'(dig[1]), 32'h9999);
      chk("upstop_done", 32'(done[1]), 32'h1);

      // direction change mid-count takes effect on the next tick only
      lv = 16'h0500; load = 1; step(1); load = 0;
      en = 1; step(2);
      chk("mid_0502", 32'(dig[0]), 32'h0502);
      up = 0; step(1); en = 0;
      chk("mid_0501", 32'(dig[0]), 32'h0501);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
